// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states and grant encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StData  = 2'd2
    } state_e;

    typedef enum logic {
        GntIf = 1'b0,
        GntD  = 1'b1
    } grant_e;

    function automatic grant_e other_grant(grant_e g);
        return (g == GntIf) ? GntD : GntIf;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; on a tie the side that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output grant_e     grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = GntIf;
        case (req_i)
            2'b01:   grant_o = GntIf;
            2'b10:   grant_o = GntD;
            2'b11:   grant_o = other_grant(last_grant_i);
            default: grant_o = GntIf;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one
// transaction at a time, with two-way round-robin on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_ack_o,
    output logic [XLEN-1:0]   if_rdata_o,

    input  logic              d_req_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    input  logic [XLEN/8-1:0] d_we_i,
    output logic              d_ack_o,
    output logic [XLEN-1:0]   d_rdata_o,

    output logic              m_req_o,
    output logic [XLEN-1:0]   m_addr_o,
    output logic [XLEN-1:0]   m_wdata_o,
    output logic [XLEN/8-1:0] m_we_o,
    input  logic              m_ack_i,
    input  logic [XLEN-1:0]   m_rdata_i
);

    localparam int unsigned StrbW = XLEN / 8;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              m_req_q, m_req_d;
    logic [XLEN-1:0]   m_addr_q, m_addr_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [StrbW-1:0]  m_we_q, m_we_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;

    logic [1:0]        eligible;
    grant_e            pick;
    logic              pick_valid;

    // A request whose ack is visible this cycle is the tail of a finished
    // transaction, not a new one.
    assign eligible = {d_req_i & ~d_ack_q, if_req_i & ~if_ack_q};

    rr_arb2 u_rr_arb2 (
        .req_i        (eligible),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_req_d      = m_req_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_we_d       = m_we_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    m_req_d      = 1'b1;
                    last_grant_d = pick;
                    if (pick == GntIf) begin
                        m_addr_d  = if_addr_i;
                        m_wdata_d = '0;
                        m_we_d    = '0;
                        state_d   = StFetch;
                    end else begin
                        m_addr_d  = d_addr_i;
                        m_wdata_d = d_wdata_i;
                        m_we_d    = d_we_i;
                        state_d   = StData;
                    end
                end
            end
            StFetch: begin
                if (m_ack_i) begin
                    m_req_d    = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = m_rdata_i;
                    state_d    = StIdle;
                end
            end
            StData: begin
                if (m_ack_i) begin
                    m_req_d = 1'b0;
                    d_ack_d = 1'b1;
                    // Stores keep the last load result visible.
                    if (m_we_q == '0) begin
                        d_rdata_d = m_rdata_i;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_grant_q <= GntD;
            m_req_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_we_q       <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_we_q       <= m_we_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_req_o    = m_req_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign m_we_o     = m_we_q;
    assign if_ack_o   = if_ack_q;
    assign d_ack_o    = d_ack_q;
    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-cycle-latency memory responder.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic        m_ack;
    logic [31:0] m_rdata;

    int vectors;
    int miscompares;
    int if_cnt;
    int d_cnt;
    bit mem_en;
    bit stray;
    logic [31:0] mem_rdata_v;
    bit grant_log[$];

    mem_arbiter #(.XLEN(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_ack_o   (if_ack),
        .if_rdata_o (if_rdata),
        .d_req_i    (d_req),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_we_i     (d_we),
        .d_ack_o    (d_ack),
        .d_rdata_o  (d_rdata),
        .m_req_o    (m_req),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_we_o     (m_we),
        .m_ack_i    (m_ack),
        .m_rdata_i  (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks two cycles after m_req rises, or a one-off stray ack on demand.
    initial begin
        int cnt;
        cnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_ack) begin
                m_ack = 1'b0;
                cnt = 0;
            end else if (stray) begin
                m_ack = 1'b1;
                m_rdata = 32'hFFFF_FFFF;
                stray = 1'b0;
            end else if (mem_en && m_req) begin
                cnt++;
                if (cnt == 2) begin
                    m_ack = 1'b1;
                    m_rdata = mem_rdata_v;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Ack counters and grant order (1 = data, identified by nonzero strobes).
    initial begin
        bit prev;
        prev = 1'b0;
        if_cnt = 0;
        d_cnt = 0;
        forever begin
            @(negedge clk);
            if (m_req && !prev) grant_log.push_back(m_we != 4'h0);
            prev = m_req;
            if (if_ack) if_cnt++;
            if (d_ack) d_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // which: 0 m_req, 1 if_ack, 2 d_ack, 3 either ack. Returns at the negedge it is seen.
    task automatic wait_for(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((which == 0 && m_req) || (which == 1 && if_ack) || (which == 2 && d_ack) ||
                (which == 3 && (if_ack || d_ack))) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        bit ok;
        int ib;
        int db;
        vectors = 0;
        miscompares = 0;
        mem_en = 1'b1;
        stray = 1'b0;
        mem_rdata_v = '0;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        d_we = '0;
        resetn = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_req", {31'b0, m_req}, 32'h0);
        check("rst_acks", {30'b0, if_ack, d_ack}, 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_we", {28'b0, m_we}, 32'h0);
        check("rst_rdata", if_rdata | d_rdata, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single fetch
        grant_log.delete();
        ib = if_cnt;
        db = d_cnt;
        mem_rdata_v = 32'h0000_0013;
        @(posedge clk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h100;
        wait_for(0, ok);
        check("f1_mreq_seen", {31'b0, ok}, 32'h1);
        check("f1_m_addr", m_addr, 32'h100);
        check("f1_m_we", {28'b0, m_we}, 32'h0);
        check("f1_m_wdata", m_wdata, 32'h0);
        wait_for(1, ok);
        check("f1_ack_seen", {31'b0, ok}, 32'h1);
        check("f1_if_rdata", if_rdata, 32'h13);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        repeat (5) @(negedge clk);
        check("f1_if_ack_once", if_cnt - ib, 32'd1);
        check("f1_no_d_ack", d_cnt - db, 32'd0);
        check("f1_one_txn", grant_log.size(), 32'd1);

        // Simultaneous requests right after reset: fetch first
        do_reset();
        grant_log.delete();
        db = d_cnt;
        mem_rdata_v = 32'h0000_0033;
        @(posedge clk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h104;
        d_req = 1'b1;
        d_addr = 32'h2000;
        d_we = 4'hF;
        d_wdata = 32'hDEAD_BEEF;
        wait_for(0, ok);
        check("tie_mreq_seen", {31'b0, ok}, 32'h1);
        check("tie_first_addr", m_addr, 32'h104);
        check("tie_first_we", {28'b0, m_we}, 32'h0);
        wait_for(1, ok);
        check("tie_if_ack_seen", {31'b0, ok}, 32'h1);
        check("tie_no_d_ack_yet", d_cnt - db + {31'b0, d_ack}, 32'd0);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        wait_for(0, ok);
        check("tie_d_mreq_seen", {31'b0, ok}, 32'h1);
        check("tie_d_addr", m_addr, 32'h2000);
        check("tie_d_we", {28'b0, m_we}, 32'hF);
        check("tie_d_wdata", m_wdata, 32'hDEAD_BEEF);
        wait_for(2, ok);
        check("tie_d_ack_seen", {31'b0, ok}, 32'h1);
        check("tie_store_d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        repeat (4) @(negedge clk);
        check("tie_two_txns", grant_log.size(), 32'd2);

        // Both held continuously: strict alternation
        grant_log.delete();
        ib = if_cnt;
        db = d_cnt;
        mem_rdata_v = 32'h0000_0011;
        if_addr = 32'h200;
        d_addr = 32'h3000;
        d_we = 4'h3;
        d_wdata = 32'h0102_0304;
        if_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_for(3, ok);
            check("rr_ack_seen", {31'b0, ok}, 32'h1);
            @(posedge clk);
            #1;
            if (if_cnt - ib == 3) if_req = 1'b0;
            if (d_cnt - db == 3) d_req = 1'b0;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (5) @(negedge clk);
        check("rr_count", grant_log.size(), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            check($sformatf("rr_order_%0d", k), {31'b0, grant_log[k]}, k % 2);
        end

        // Load then store: store keeps the load result
        grant_log.delete();
        mem_rdata_v = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_addr = 32'h40;
        d_we = 4'h0;
        d_wdata = 32'h0;
        wait_for(0, ok);
        check("ld_m_addr", m_addr, 32'h40);
        check("ld_m_we", {28'b0, m_we}, 32'h0);
        wait_for(2, ok);
        check("ld_ack_seen", {31'b0, ok}, 32'h1);
        check("ld_d_rdata", d_rdata, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        mem_rdata_v = 32'h1234_5678;
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_addr = 32'h44;
        d_we = 4'hF;
        d_wdata = 32'h5555_AAAA;
        wait_for(2, ok);
        check("st_ack_seen", {31'b0, ok}, 32'h1);
        check("st_d_rdata_kept", d_rdata, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        repeat (5) @(negedge clk);
        check("ldst_no_dup", grant_log.size(), 32'd2);
        check("ldst_idle_mreq", {31'b0, m_req}, 32'h0);

        // Asynchronous reset mid-data-transaction, then a stray m_ack in idle
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_addr = 32'h80;
        d_we = 4'h1;
        wait_for(0, ok);
        check("ar_mreq_seen", {31'b0, ok}, 32'h1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_m_req", {31'b0, m_req}, 32'h0);
        check("ar_acks", {30'b0, if_ack, d_ack}, 32'h0);
        check("ar_m_addr", m_addr, 32'h0);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ib = if_cnt;
        db = d_cnt;
        stray = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_no_ack", (if_cnt - ib) + (d_cnt - db), 32'd0);
        check("stray_m_req", {31'b0, m_req}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the CPU's instruction-fetch requester and data load/store requester.
- Replaces the split ROM/data-memory interface so the core can run from a single RAM.
- Sequences one memory transaction at a time with a req/ack handshake and routes the response back to the granted requester.
- Simultaneous requests are resolved by two-way round-robin, so neither side starves.

Parameters:
- XLEN, 32, data and address width; byte-strobe width is XLEN/8.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  XLEN  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  XLEN  fetched word; valid with if_ack, held until the next if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_we  in  XLEN/8  byte write strobes; all zero means load.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  XLEN  load word; valid with d_ack, held until the next load ack.
- m_req  out  1  memory request.
- m_addr  out  XLEN  memory address.
- m_wdata  out  XLEN  memory write data.
- m_we  out  XLEN/8  memory byte strobes.
- m_ack  in  1  memory completion pulse; m_rdata valid in the same cycle.
- m_rdata  in  XLEN  memory read data.

Behaviour:
- FSM states: IDLE, FETCH, DATA. Reset state is IDLE.
- Reset values: all outputs 0. last_grant resets to DATA, so fetch wins the first tie.
- Eligibility in IDLE: a requester is eligible when its req is high and its own ack is not asserted this cycle. This stops a request being re-served in the cycle its ack is visible.
- IDLE with exactly one eligible requester: grant it.
- IDLE with both eligible: grant the one not equal to last_grant.
- On grant: m_req, m_addr, m_wdata and m_we are registered from the granted requester. They appear the next cycle and stay stable until m_ack.
  - Fetch grant drives m_we = 0 and m_wdata = 0.
  - Next state is FETCH or DATA; last_grant is updated.
- FETCH/DATA with m_ack low: hold all outputs.
- FETCH/DATA with m_ack high, next edge:
  - m_req drops to 0.
  - The granted requester's ack pulses for one cycle.
  - The granted requester's rdata is loaded from m_rdata; for stores (d_we nonzero) d_rdata is unchanged.
  - FSM returns to IDLE.
- Latency: request high at edge N gives m_req high at N+1. m_ack high at edge M gives the requester ack at M+1. The earliest next m_req is M+2. Minimum round trip is 2 cycles plus memory latency.
- m_ack while in IDLE is ignored; no ack, no state change.
- A requester dropping req mid-transaction is illegal. The arbiter still completes the transaction and pulses ack.
- Address and write data are captured at grant; later input changes do not affect the in-flight transaction.
- resetn low mid-transaction: immediately returns to IDLE and clears all outputs. The in-flight memory access is abandoned; memory must tolerate m_req dropping without ack.
- No timeout; a memory that never acks stalls forever.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, FETCH, DATA) and grant encoding (GNT_IF = 0, GNT_D = 1).
- Sub-module rr_arb2: combinational two-input round-robin picker taking req[1:0] and last_grant and returning grant plus valid. Instantiated once.
- All registers live in mem_arbiter.

Test Plan:
- Reset, then if_req with if_addr = 0x100, memory acks 2 cycles after m_req with m_rdata = 0x00000013 -> m_addr = 0x100, m_we = 0, if_ack pulses once, if_rdata = 0x13, d_ack stays 0.
- if_req and d_req rise together, d_addr = 0x2000, d_we = 0xF, d_wdata = 0xDEADBEEF -> fetch served first; then data with m_we = 0xF and m_wdata = 0xDEADBEEF; ack order if then d.
- Both requests held continuously for 6 transactions -> grants strictly alternate if, d, if, d, if, d.
- Load with d_we = 0, d_addr = 0x40, m_rdata = 0xCAFEF00D -> d_rdata = 0xCAFEF00D. A following store leaves d_rdata = 0xCAFEF00D.
- Requester holds req one cycle after its ack -> no duplicate m_req; exactly one transaction per request.
- resetn pulsed low while in DATA, before m_ack -> m_req, d_ack and if_ack are 0 immediately. A stray m_ack afterwards in IDLE produces no ack.
